// File: rtl/npc_mem_responder_if.sv
// npc_mem_responder_if: valid/ready request and response channels
// between a core-side initiator (master) and the memory responder (slave).
interface npc_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/npc_mem_responder.sv
// npc_mem_responder: one-at-a-time word RAM responder with fixed latency.
// Define NPC_MEM_ALIGN_CHECK_EN to fault any access with addr[1:0] != 0.
module npc_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          ADDR_W    = 16,
  parameter int          LATENCY   = 1
) (
  input logic               clk,
  input logic               reset,
  npc_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int          WORDS = 1 << ADDR_W;
  localparam logic [32:0] LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI    =
    LO + (33'd1 << (ADDR_W + 2)) - 33'd1;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [WORDS];
  logic [31:0] rdata;
  logic        valid;
  logic        err;

  logic [32:0]       addr_x;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              fault;
  logic              accept;

  // Range test is done in 33 bits so the top of memory cannot wrap.
  assign addr_x   = {1'b0, bus.req_addr};
  assign in_range = (addr_x >= LO) && (addr_x <= HI);
  assign idx      = bus.req_addr[ADDR_W+1:2]
                  - BASE_ADDR[ADDR_W+1:2];

`ifdef NPC_MEM_ALIGN_CHECK_EN
  assign fault = !in_range || (bus.req_addr[1:0] != 2'b00);
`else
  assign fault = !in_range;
`endif

  assign accept = bus.req_valid && (state == IDLE) && !reset;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = valid;
  assign bus.resp_rdata = rdata;
  assign bus.resp_err   = err;

  always_ff @(posedge clk) begin
    if (accept && bus.req_wen && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_wmask[i])
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      valid <= 1'b0;
      rdata <= 32'd0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rdata <= (!fault && !bus.req_wen) ? mem[idx] : 32'd0;
            err   <= fault;
            cnt   <= LAT;
            if (LAT != 4'd0) begin
              state <= WAIT;
            end else begin
              state <= RESP;
              valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state <= IDLE;
            valid <= 1'b0;
            rdata <= 32'd0;
            err   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_npc_mem_responder.sv
// tb_npc_mem_responder: vector table, hand sequences and random traffic
// against an array-based memory model; honours NPC_MEM_ALIGN_CHECK_EN.
module tb_npc_mem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          AW   = 8;
  localparam int          NW   = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  npc_mem_responder_if b2 ();
  npc_mem_responder_if b0 ();

  npc_mem_responder #(
    .BASE_ADDR(BASE), .ADDR_W(AW), .LATENCY(2)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  npc_mem_responder #(
    .BASE_ADDR(BASE), .ADDR_W(AW), .LATENCY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] mref [NW];

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [19];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endfunction

  function automatic void timeout_fail(string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting", nm);
  endfunction

  function automatic logic [31:0] init_val(int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory model: plain array indexed by word offset from BASE.
  function automatic void model(
    input logic wen, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [3:0] wmask,
    output logic [31:0] rd, output logic er);
    longint a, lo, hi;
    int w;
    a  = {32'h0, addr};
    lo = {32'h0, BASE};
    hi = lo + 4 * NW - 1;
    er = (a < lo) || (a > hi);
`ifdef NPC_MEM_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) er = 1'b1;
`endif
    rd = 32'd0;
    if (!er) begin
      w = int'((a - lo) / 4);
      if (wen) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) mref[w][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rd = mref[w];
      end
    end
  endfunction

  task automatic txn(
    input logic wen, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [3:0] wmask,
    input int stall,
    output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_wen   = wen;
    b2.req_addr  = addr;
    b2.req_wdata = wdata;
    b2.req_wmask = wmask;
    n = 0;
    while (!b2.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) timeout_fail("req_ready");
    @(posedge clk);
    #1 b2.req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!b2.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat == 40) timeout_fail("resp_valid");
    rd = b2.resp_rdata;
    er = b2.resp_err;
    repeat (stall) @(negedge clk);
    b2.resp_ready = 1'b1;
    @(posedge clk);
    #1 b2.resp_ready = 1'b0;
  endtask

  task automatic run(
    string nm, input logic wen, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [3:0] wmask,
    input int stall,
    input logic [31:0] e_rd, input logic e_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(wen, addr, wdata, wmask, stall, rd, er, lat);
    chk({nm, " rdata"}, rd, e_rd);
    chk({nm, " err"}, 32'(er), 32'(e_er));
    chk({nm, " latency"}, 32'(lat), 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_rd;
    logic        e_er;
    logic [31:0] iv3;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [3:0]  r_wm;
    logic        r_wen;
    int          n;
    int          j;
    int          jprev;
    int          r;

    b2.req_valid  = 1'b0;
    b2.req_wen    = 1'b0;
    b2.req_addr   = 32'd0;
    b2.req_wdata  = 32'd0;
    b2.req_wmask  = 4'd0;
    b2.resp_ready = 1'b0;
    b0.req_valid  = 1'b0;
    b0.req_wen    = 1'b0;
    b0.req_addr   = 32'd0;
    b0.req_wdata  = 32'd0;
    b0.req_wmask  = 4'd0;
    b0.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst req_ready", 32'(b2.req_ready), 32'd1);
    chk("rst resp_valid", 32'(b2.resp_valid), 32'd0);
    chk("rst resp_rdata", b2.resp_rdata, 32'd0);
    chk("rst resp_err", 32'(b2.resp_err), 32'd0);
    chk("rst l0 req_ready", 32'(b0.req_ready), 32'd1);

    for (int i = 0; i < NW; i++) begin
      model(1'b1, BASE + 32'(4 * i), init_val(i), 4'hF,
            e_rd, e_er);
      run("init", 1'b1, BASE + 32'(4 * i), init_val(i),
          4'hF, 0, e_rd, e_er);
    end

    iv3 = init_val(3);
    vecs[0]  = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF,
                 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0,
                 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'h0000_00AA, 4'h1,
                 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0,
                 32'hDEAD_BEAA, 1'b0};
    vecs[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0,
                 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h8000_0400, 32'h0, 4'h0,
                 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h8000_0400, 32'h1111_1111, 4'hF,
                 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0,
                 32'hDEAD_BEAA, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF,
                 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 32'h8000_03FC, 32'hA5A5_A5A5, 4'hF,
                 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h8000_03FC, 32'h0, 4'h0,
                 32'hA5A5_A5A5, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0008, 32'hFFFF_FFFF, 4'h0,
                 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h8000_0008, 32'h0, 4'h0,
                 init_val(2), 1'b0};
    vecs[13] = '{1'b1, 32'h8000_000C, 32'hAABB_CCDD, 4'hA,
                 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_000C, 32'h0, 4'h0,
                 {8'hAA, iv3[23:16], 8'hCC, iv3[7:0]}, 1'b0};
    vecs[15] = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF,
                 32'h0, 1'b0};
`ifdef NPC_MEM_ALIGN_CHECK_EN
    vecs[16] = '{1'b0, 32'h8000_0002, 32'h0, 4'h0,
                 32'h0, 1'b1};
    vecs[17] = '{1'b0, 32'h8000_03FF, 32'h0, 4'h0,
                 32'h0, 1'b1};
`else
    vecs[16] = '{1'b0, 32'h8000_0002, 32'h0, 4'h0,
                 32'hCAFE_F00D, 1'b0};
    vecs[17] = '{1'b0, 32'h8000_03FF, 32'h0, 4'h0,
                 32'hA5A5_A5A5, 1'b0};
`endif
    vecs[18] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0,
                 32'h0, 1'b1};

    for (int i = 0; i < 19; i++) begin
      model(vecs[i].wen, vecs[i].addr, vecs[i].wdata,
            vecs[i].wmask, e_rd, e_er);
      run($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr,
          vecs[i].wdata, vecs[i].wmask, 0,
          vecs[i].rdata, vecs[i].err);
    end

    @(negedge clk);
    chk("post resp_valid", 32'(b2.resp_valid), 32'd0);
    chk("post resp_rdata", b2.resp_rdata, 32'd0);
    chk("post req_ready", 32'(b2.req_ready), 32'd1);

    // Backpressure: response held while a stray request is ignored.
    b2.req_valid = 1'b1;
    b2.req_wen   = 1'b0;
    b2.req_addr  = 32'h8000_0004;
    @(posedge clk);
    #1 b2.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!b2.resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) timeout_fail("stall resp_valid");
    chk("stall latency", 32'(n), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk("stall resp_valid", 32'(b2.resp_valid), 32'd1);
      chk("stall resp_rdata", b2.resp_rdata, 32'h1234_5678);
      chk("stall resp_err", 32'(b2.resp_err), 32'd0);
      chk("stall req_ready", 32'(b2.req_ready), 32'd0);
      if (k == 2) begin
        b2.req_valid = 1'b1;
        b2.req_wen   = 1'b1;
        b2.req_wdata = 32'h0;
        b2.req_wmask = 4'hF;
      end else begin
        b2.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    b2.resp_ready = 1'b1;
    @(posedge clk);
    #1 b2.resp_ready = 1'b0;
    @(negedge clk);
    chk("release req_ready", 32'(b2.req_ready), 32'd1);
    chk("release resp_valid", 32'(b2.resp_valid), 32'd0);
    chk("release resp_rdata", b2.resp_rdata, 32'd0);
    chk("release resp_err", 32'(b2.resp_err), 32'd0);
    model(1'b0, 32'h8000_0004, 32'h0, 4'h0, e_rd, e_er);
    run("stray ignored", 1'b0, 32'h8000_0004, 32'h0, 4'h0, 0,
        e_rd, e_er);

    // Reset during WAIT: response dropped, committed write kept.
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_wen   = 1'b1;
    b2.req_addr  = 32'h8000_0010;
    b2.req_wdata = 32'h7777_7777;
    b2.req_wmask = 4'hF;
    @(posedge clk);
    #1 b2.req_valid = 1'b0;
    model(1'b1, 32'h8000_0010, 32'h7777_7777, 4'hF, e_rd, e_er);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst req_ready", 32'(b2.req_ready), 32'd1);
    chk("midrst resp_valid", 32'(b2.resp_valid), 32'd0);
    @(negedge clk);
    chk("midrst resp_valid+1", 32'(b2.resp_valid), 32'd0);
    model(1'b0, 32'h8000_0010, 32'h0, 4'h0, e_rd, e_er);
    run("midrst persist", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0,
        e_rd, e_er);
    chk("midrst model", e_rd, 32'h7777_7777);

    for (int t = 0; t < 150; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)
        r_addr = BASE + $urandom_range(0, 4 * NW - 1);
      else if (r == 7)
        r_addr = BASE - $urandom_range(1, 16);
      else if (r == 8)
        r_addr = BASE + 32'(4 * NW) + $urandom_range(0, 15);
      else
        r_addr = $urandom;
      r_wen = 1'($urandom_range(0, 1));
      r_wd  = $urandom;
      r_wm  = 4'($urandom_range(0, 15));
      model(r_wen, r_addr, r_wd, r_wm, e_rd, e_er);
      run($sformatf("rand%0d", t), r_wen, r_addr, r_wd, r_wm,
          int'($urandom_range(0, 3)), e_rd, e_er);
    end

    // Zero latency: accept, respond, accept... with ready tied high.
    b0.resp_ready = 1'b1;
    j = 0;
    jprev = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      chk("l0 req_ready", 32'(b0.req_ready), 32'(c % 2 == 0));
      chk("l0 resp_valid", 32'(b0.resp_valid), 32'(c % 2 == 1));
      if (c % 2 == 1)
        chk("l0 resp_rdata", b0.resp_rdata,
            (jprev >= 4) ? 32'h0B0B_0000 + 32'(jprev - 4)
                         : 32'd0);
      if (b0.req_ready) begin
        if (j < 8) begin
          b0.req_valid = 1'b1;
          b0.req_wen   = (j < 4);
          b0.req_addr  = BASE + 32'(4 * (j % 4));
          b0.req_wdata = 32'h0B0B_0000 + 32'(j);
          b0.req_wmask = 4'hF;
          jprev = j;
          j++;
        end else begin
          b0.req_valid = 1'b0;
        end
      end
    end
    b0.req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
